// File: rtl/timer_bus_sequencer.sv
// Wishbone front end for the 8254-style timer (ports 0x40-0x43): splits byte-lane accesses into
// ordered single-byte counter operations. Define TIMER_IRQ_LATCH_EN for latched IRQ0 with ack.
module timer_bus_sequencer #(
   parameter int RD_HOLD = 2,
   parameter int GAP     = 1
) (
   input  logic        clkrw,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic        wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        cnt_wrc,
   output logic [2:0]  cnt_wrd,
   output logic [2:0]  cnt_rdd,
   output logic [7:0]  cnt_dat_o,
   input  logic [7:0]  cnt_dat_i0,
   input  logic [7:0]  cnt_dat_i1,
   input  logic [7:0]  cnt_dat_i2,
   input  logic        cnt_out0,
   input  logic        irq_ack_i,
   output logic        irq_o
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WPULSE, S_RDD, S_GAPS, S_ACK} state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_cnt;
   logic [1:0]  r_pend;
   logic        r_lane, r_adr, r_we;
   logic [1:0]  w_port;
   logic [3:0]  w_dec;
   logic        w_rd_last, w_gap_last, w_other, w_req;
   logic [7:0]  w_rd_byte;

   assign w_req      = wb_cyc_i & wb_stb_i;
   assign w_port     = {r_adr, r_lane};
   assign w_dec      = 4'b0001 << w_port;
   assign w_rd_last  = (r_cnt == 8'(RD_HOLD - 1));
   assign w_gap_last = (r_cnt == 8'(GAP - 1));
   // Low lane is always served first, so only the high lane can still be pending.
   assign w_other    = r_pend[1] & ~r_lane;

   always_comb begin
      case (w_port)
         2'd0:    w_rd_byte = cnt_dat_i0;
         2'd1:    w_rd_byte = cnt_dat_i1;
         2'd2:    w_rd_byte = cnt_dat_i2;
         default: w_rd_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clkrw) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      wb_ack_o = 1'b0;
      cnt_wrc  = 1'b0;
      cnt_wrd  = 3'b000;
      cnt_rdd  = 3'b000;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_next = (wb_sel_i == 2'b00) ? S_ACK : S_SETUP;
         end
         S_SETUP: w_next = r_we ? S_WPULSE : S_RDD;
         S_WPULSE: begin
            cnt_wrc = w_dec[3];
            cnt_wrd = w_dec[2:0];
            w_next  = S_GAPS;
         end
         S_RDD: begin
            cnt_rdd = w_dec[2:0];
            if (w_rd_last) w_next = S_GAPS;
         end
         S_GAPS: begin
            if (w_gap_last) begin
               if (!wb_cyc_i)    w_next = S_IDLE;
               else if (w_other) w_next = S_SETUP;
               else              w_next = S_ACK;
            end
         end
         S_ACK: begin
            wb_ack_o = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // cnt_dat_o is loaded on entry to SETUP so it is stable for the whole SETUP + pulse window.
   always_ff @(posedge clkrw) begin
      if (rst) begin
         r_cnt     <= 8'd0;
         r_pend    <= 2'b00;
         r_lane    <= 1'b0;
         r_adr     <= 1'b0;
         r_we      <= 1'b0;
         cnt_dat_o <= 8'd0;
         wb_dat_o  <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_pend    <= wb_sel_i;
                  r_lane    <= ~wb_sel_i[0];
                  r_adr     <= wb_adr_i;
                  r_we      <= wb_we_i;
                  r_cnt     <= 8'd0;
                  cnt_dat_o <= wb_sel_i[0] ? wb_dat_i[7:0] : wb_dat_i[15:8];
                  if (!wb_we_i || wb_sel_i == 2'b00) wb_dat_o <= 16'd0;
               end
            end
            S_RDD: begin
               if (w_rd_last) begin
                  r_cnt <= 8'd0;
                  if (r_lane) wb_dat_o[15:8] <= w_rd_byte;
                  else        wb_dat_o[7:0]  <= w_rd_byte;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_GAPS: begin
               if (w_gap_last) begin
                  r_cnt          <= 8'd0;
                  r_pend[r_lane] <= 1'b0;
                  r_lane         <= 1'b1;
                  cnt_dat_o      <= wb_dat_i[15:8];
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TIMER_IRQ_LATCH_EN
   logic r_out0_q;

   always_ff @(posedge clkrw) begin
      if (rst) begin
         r_out0_q <= 1'b0;
         irq_o    <= 1'b0;
      end else begin
         r_out0_q <= cnt_out0;
         if (cnt_out0 && !r_out0_q) irq_o <= 1'b1;
         else if (irq_ack_i)        irq_o <= 1'b0;
      end
   end
`else
   logic w_unused_ack;
   assign w_unused_ack = irq_ack_i;

   always_ff @(posedge clkrw) begin
      if (rst) irq_o <= 1'b0;
      else     irq_o <= cnt_out0;
   end
`endif

endmodule

// File: tb/tb_timer_bus_sequencer.sv
// Directed bench for timer_bus_sequencer: vector table of bus transactions plus hand-written
// reset-abort, cyc-drop and IRQ sequences.
module tb_timer_bus_sequencer;

   logic        clkrw = 1'b0;
   logic        rst;
   logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i;
   logic [1:0]  wb_sel_i;
   logic [15:0] wb_dat_i, wb_dat_o;
   logic        wb_ack_o, cnt_wrc;
   logic [2:0]  cnt_wrd, cnt_rdd;
   logic [7:0]  cnt_dat_o, cnt_dat_i0, cnt_dat_i1, cnt_dat_i2;
   logic        cnt_out0, irq_ack_i, irq_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clkrw = ~clkrw;

   timer_bus_sequencer dut (
      .clkrw(clkrw), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
      .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .cnt_wrc(cnt_wrc), .cnt_wrd(cnt_wrd), .cnt_rdd(cnt_rdd), .cnt_dat_o(cnt_dat_o),
      .cnt_dat_i0(cnt_dat_i0), .cnt_dat_i1(cnt_dat_i1), .cnt_dat_i2(cnt_dat_i2),
      .cnt_out0(cnt_out0), .irq_ack_i(irq_ack_i), .irq_o(irq_o)
   );

   typedef struct {
      logic        we;
      logic        adr;
      logic [1:0]  sel;
      logic [15:0] dat;
      logic [7:0]  d0, d1, d2;
      int          lat;
      int          wrc;
      int          wrd0, wrd1, wrd2;
      int          rdd0, rdd1, rdd2;
      logic [15:0] dato;
      logic [7:0]  cdat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_xact(input int idx, input vec_t v);
      int         lat, wrc;
      int         wrd[3];
      int         rdd[3];
      logic [7:0] cd;
      bit         got, ovl, rdd_prev, rdd_at_ack;
      lat = 0; wrc = 0; cd = 8'h00; got = 0; ovl = 0; rdd_prev = 0; rdd_at_ack = 0;
      for (int k = 0; k < 3; k++) begin wrd[k] = 0; rdd[k] = 0; end
      @(negedge clkrw);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we; wb_adr_i = v.adr;
      wb_sel_i = v.sel; wb_dat_i = v.dat;
      cnt_dat_i0 = v.d0; cnt_dat_i1 = v.d1; cnt_dat_i2 = v.d2;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(posedge clkrw); #1;
         if (wb_ack_o) begin got = 1; lat = c; rdd_at_ack = rdd_prev; end
         if (cnt_wrc) wrc++;
         for (int k = 0; k < 3; k++) begin
            if (cnt_wrd[k]) wrd[k]++;
            if (cnt_rdd[k]) rdd[k]++;
         end
         if (cnt_wrc || cnt_wrd != 3'b000) cd = cnt_dat_o;
         if (int'(cnt_wrc) + $countones(cnt_wrd) + $countones(cnt_rdd) > 1) ovl = 1;
         rdd_prev = |cnt_rdd;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      chk($sformatf("v%0d ack", idx), 32'(got), 32'd1);
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d wrc", idx), 32'(wrc), 32'(v.wrc));
      chk($sformatf("v%0d wrd0", idx), 32'(wrd[0]), 32'(v.wrd0));
      chk($sformatf("v%0d wrd1", idx), 32'(wrd[1]), 32'(v.wrd1));
      chk($sformatf("v%0d wrd2", idx), 32'(wrd[2]), 32'(v.wrd2));
      chk($sformatf("v%0d rdd0", idx), 32'(rdd[0]), 32'(v.rdd0));
      chk($sformatf("v%0d rdd1", idx), 32'(rdd[1]), 32'(v.rdd1));
      chk($sformatf("v%0d rdd2", idx), 32'(rdd[2]), 32'(v.rdd2));
      chk($sformatf("v%0d strobe overlap", idx), 32'(ovl), 32'd0);
      chk($sformatf("v%0d rdd low before ack", idx), 32'(rdd_at_ack), 32'd0);
      chk($sformatf("v%0d wb_dat_o", idx), 32'(wb_dat_o), 32'(v.dato));
      if (v.we && v.sel != 2'b00) chk($sformatf("v%0d cnt_dat_o", idx), 32'(cd), 32'(v.cdat));
      @(posedge clkrw);
   endtask

   initial begin
      //          we    adr   sel    dat       d0     d1     d2    lat wrc wrd0..2 rdd0..2  dato      cdat
      vecs[0] = '{1'b1, 1'b1, 2'b10, 16'h3600, 8'h00, 8'h00, 8'h00, 4, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h36};
      vecs[1] = '{1'b1, 1'b0, 2'b01, 16'h009C, 8'h00, 8'h00, 8'h00, 4, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h9C};
      vecs[2] = '{1'b1, 1'b0, 2'b01, 16'h002E, 8'h00, 8'h00, 8'h00, 4, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h2E};
      vecs[3] = '{1'b0, 1'b0, 2'b01, 16'h0000, 8'h12, 8'h00, 8'h00, 5, 0, 0, 0, 0, 2, 0, 0, 16'h0012, 8'h00};
      vecs[4] = '{1'b0, 1'b1, 2'b11, 16'h0000, 8'h00, 8'h00, 8'h5A, 9, 0, 0, 0, 0, 0, 0, 2, 16'hFF5A, 8'h00};
      vecs[5] = '{1'b1, 1'b0, 2'b11, 16'h3412, 8'h00, 8'h00, 8'h00, 7, 0, 1, 1, 0, 0, 0, 0, 16'hFF5A, 8'h34};
      vecs[6] = '{1'b0, 1'b0, 2'b10, 16'h0000, 8'h00, 8'hA7, 8'h00, 5, 0, 0, 0, 0, 0, 2, 0, 16'hA700, 8'h00};
      vecs[7] = '{1'b1, 1'b0, 2'b00, 16'hFFFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00};
      vecs[8] = '{1'b1, 1'b1, 2'b01, 16'h00C5, 8'h00, 8'h00, 8'h00, 4, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 8'hC5};
      vecs[9] = '{1'b0, 1'b1, 2'b10, 16'h0000, 8'h00, 8'h00, 8'h00, 5, 0, 0, 0, 0, 0, 0, 0, 16'hFF00, 8'h00};

      rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0;
      wb_sel_i = 2'b00; wb_dat_i = 16'h0000; cnt_dat_i0 = 8'h00; cnt_dat_i1 = 8'h00;
      cnt_dat_i2 = 8'h00; cnt_out0 = 1'b0; irq_ack_i = 1'b0;
      repeat (3) @(posedge clkrw);
      #1;
      chk("reset ack", 32'(wb_ack_o), 32'd0);
      chk("reset wrc/wrd/rdd", {25'd0, cnt_wrc, cnt_wrd, cnt_rdd}, 32'd0);
      chk("reset wb_dat_o", 32'(wb_dat_o), 32'd0);
      chk("reset cnt_dat_o", 32'(cnt_dat_o), 32'd0);
      chk("reset irq_o", 32'(irq_o), 32'd0);
      @(negedge clkrw);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_xact(i, vecs[i]);

      // reset while a read strobe is active
      @(negedge clkrw);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0;
      wb_sel_i = 2'b01; cnt_dat_i0 = 8'h77;
      @(posedge clkrw); @(posedge clkrw); #1;
      chk("rstmid rdd0 active", 32'(cnt_rdd), 32'd1);
      @(negedge clkrw);
      rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(posedge clkrw); #1;
      chk("rstmid strobes", {25'd0, cnt_wrc, cnt_wrd, cnt_rdd}, 32'd0);
      chk("rstmid ack", 32'(wb_ack_o), 32'd0);
      chk("rstmid wb_dat_o", 32'(wb_dat_o), 32'd0);
      @(negedge clkrw);
      rst = 1'b0;
      run_xact(10, '{1'b0, 1'b0, 2'b01, 16'h0000, 8'h77, 8'h00, 8'h00, 5, 0, 0, 0, 0, 2, 0, 0,
                     16'h0077, 8'h00});

      // cyc dropped after the first byte pulse of a two-lane write
      begin
         int acks, w1, w0;
         acks = 0; w1 = 0; w0 = 0;
         @(negedge clkrw);
         wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 1'b0;
         wb_sel_i = 2'b11; wb_dat_i = 16'hBBAA;
         @(posedge clkrw); @(posedge clkrw); #1;
         chk("cycdrop wrd0 pulse", 32'(cnt_wrd), 32'd1);
         chk("cycdrop byte", 32'(cnt_dat_o), 32'hAA);
         wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
         for (int c = 0; c < 10; c++) begin
            @(posedge clkrw); #1;
            if (wb_ack_o) acks++;
            if (cnt_wrd[1]) w1++;
            if (cnt_wrd[0]) w0++;
         end
         chk("cycdrop ack", 32'(acks), 32'd0);
         chk("cycdrop high lane", 32'(w1), 32'd0);
         chk("cycdrop no repeat", 32'(w0), 32'd0);
      end
      run_xact(11, '{1'b1, 1'b1, 2'b10, 16'h7400, 8'h00, 8'h00, 8'h00, 4, 1, 0, 0, 0, 0, 0, 0,
                     16'h0077, 8'h74});

`ifdef TIMER_IRQ_LATCH_EN
      @(negedge clkrw);
      cnt_out0 = 1'b1;
      @(posedge clkrw); #1;
      chk("irq set on rise", 32'(irq_o), 32'd1);
      @(negedge clkrw);
      cnt_out0 = 1'b0;
      repeat (3) @(posedge clkrw);
      #1;
      chk("irq held", 32'(irq_o), 32'd1);
      @(negedge clkrw);
      irq_ack_i = 1'b1;
      @(posedge clkrw); #1;
      chk("irq cleared by ack", 32'(irq_o), 32'd0);
      @(negedge clkrw);
      cnt_out0 = 1'b1;
      @(posedge clkrw); #1;
      chk("irq set wins over ack", 32'(irq_o), 32'd1);
      @(negedge clkrw);
      irq_ack_i = 1'b0;
      cnt_out0 = 1'b0;
`else
      @(negedge clkrw);
      cnt_out0 = 1'b1;
      irq_ack_i = 1'b1;
      #1;
      chk("irq before edge", 32'(irq_o), 32'd0);
      @(posedge clkrw); #1;
      chk("irq follows out0 high", 32'(irq_o), 32'd1);
      @(negedge clkrw);
      cnt_out0 = 1'b0;
      @(posedge clkrw); #1;
      chk("irq follows out0 low", 32'(irq_o), 32'd0);
      irq_ack_i = 1'b0;
`endif

      repeat (2) @(posedge clkrw);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
